jtbubl_main_comm: RTL and testbench
===================================

Name: jtbubl_main_comm

Overview:
Main-CPU-side end of the main/sound mailbox. Queues main-CPU command bytes and delivers them one at a time to the sound subsystem over snd_latch/snd_stb, pacing on snd_flag. Captures sound-CPU replies from main_latch/main_stb and raises main_flag and an optional IRQ. Also owns the sound-CPU reset line. Sits between the main CPU bus decoder and the sound block.

Parameters:
CMD_AW, 2, command FIFO address width; depth = 2**CMD_AW.
WAIT_MAX, 1023, clk cycles to wait for the sound side to take a strobed command before abandoning it.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpu_cs  in  1  main CPU selects this block
addr  in  2  register select
wr_n  in  1  CPU write strobe, active low
rd_n  in  1  CPU read strobe, active low
cpu_dout  in  8  data written by CPU
cpu_din  out  8  data read by CPU, registered
snd_latch  out  8  command byte presented to sound side
snd_stb  out  1  one-cycle strobe for snd_latch
snd_flag  in  1  sound side: 1 = latch empty/consumed, 0 = command pending
main_latch  in  8  reply byte from sound CPU
main_stb  in  1  high while the sound CPU writes the reply
main_flag  out  1  1 = unread reply pending
snd_rstn  out  1  sound CPU reset, active low
irq_n  out  1  reply interrupt to main CPU, active low

Behaviour:
- Clock is clk only. Reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Reset values: snd_latch=0, snd_stb=0, main_flag=0, snd_rstn=0 (sound held in reset), irq_n=1, cpu_din=FF, FIFO empty, all sticky bits 0, irq enable 0, FSM=IDLE.
- CPU accesses are edge-qualified. wr_act=cpu_cs&!wr_n and rd_act=cpu_cs&!rd_n are registered. Side effects fire only on the first cycle of each access, however many cycles the strobe is held.
- Write map:
  - addr0: push cpu_dout to the FIFO. If the FIFO is full, drop the byte and set ovf_cmd.
  - addr1: bit0=1 asserts sound reset (snd_rstn=0); bit1 is irq enable.
  - addr2: flush the FIFO. FSM goes to IDLE.
  - addr3: no effect.
- Read map. cpu_din is updated every clk while rd_act is high, so data is valid 1 cycle after the access starts.
  - addr0: reply byte. On the first cycle of the access, clear main_flag.
  - addr1: status {2'b0, ovf_cmd, ovf_rep, fifo_full, fifo_empty, main_flag, busy}, where busy=(FSM!=IDLE)|!snd_flag. Reading addr1 clears ovf_cmd and ovf_rep.
  - addr2: {(8-CMD_AW-1)'b0, fifo_count}.
  - addr3: FF.
- Reply capture: on the rising edge of main_stb, register main_latch and set main_flag=1.
  - If main_flag was already 1, overwrite the byte and set ovf_rep.
  - If the rising edge coincides with an addr0 read clear, the new capture wins and main_flag stays 1.
- Sender FSM states: IDLE, LOAD, STB, WAIT.
  - IDLE: go to LOAD when the FIFO is not empty, snd_flag=1 and snd_rstn=1.
  - LOAD: snd_latch<=FIFO head; pop the FIFO.
  - STB: snd_stb=1 for exactly this one cycle.
  - WAIT: go to IDLE when snd_flag==0 (taken), or when the counter reaches WAIT_MAX (command lost, no status bit).
  - Latency from a push into an empty FIFO with the sound side idle: 2 clk to the LOAD edge, snd_stb high on the 3rd cycle.
  - The next command goes out only after snd_flag returns to 1 (the sound CPU has read the previous one).
- The FIFO accepts a push and a pop in the same cycle, including when full: the pop frees the slot, so the push is accepted. fifo_count wraps never; it saturates at depth by construction.
- Sound reset mid-operation: when snd_rstn=0, the FSM forces IDLE and snd_stb=0 on the next clk. The in-flight byte is lost; FIFO contents are kept.
- Flush during STB: the strobe still completes that cycle, then the FSM goes to IDLE.

Optional Feature:
JTBUBL_COMM_IRQ_EN
- Defined: irq_n = !(main_flag & irq_en), registered, so it deasserts 1 clk after the addr0 read.
- Undefined: irq_n tied to 1, the irq_en register is not implemented, and addr1 bit1 writes are ignored.

Decomposition:
- Package jtbubl_comm_pkg:
  - register address constants (REG_DATA=0, REG_CTRL=1, REG_FLUSH/COUNT=2);
  - status bit indices;
  - FSM state enum (2-bit).
- One sub-module: jtbubl_comm_fifo, a synchronous FIFO of depth 2**CMD_AW with push, pop, flush, full, empty and count.

Test Plan:
- Reset, write CTRL=00 (release sound), push 0x5A with a sound model that drops snd_flag 1 clk after the strobe -> snd_latch=5A, a single-cycle snd_stb 3 clk after the push; status busy=1 until the model raises snd_flag.
- Push 5 bytes 01..05 with CMD_AW=2 -> the 5th is dropped and status reads 0x21 (ovf_cmd, busy; not full, because the first byte was popped); bytes 01..04 are delivered in order, each only after snd_flag returns to 1.
- Sound model pulses main_stb with main_latch=0xC3 -> main_flag=1, irq_n=0 if enabled; an addr0 read returns C3 and clears both. A second pulse before the read -> ovf_rep=1 and the latest byte is returned.
- Hold rd_n low 6 cycles on addr0 while main_stb rises on cycle 3 -> main_flag stays 1 at the end.
- Sound model never drops snd_flag after a strobe -> FSM returns to IDLE after WAIT_MAX+1 cycles and the next FIFO byte is sent.
- Write CTRL=01 while in WAIT -> snd_rstn=0, FSM IDLE next clk, no strobes while held; FIFO count unchanged.

Source files
------------

// File: rtl/jtbubl_comm_pkg.sv
// jtbubl_comm_pkg: register map, status bit positions and sender FSM states for the main/sound mailbox
package jtbubl_comm_pkg;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_FLUSH = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd2;

    localparam int BIT_BUSY    = 0;
    localparam int BIT_MFLAG   = 1;
    localparam int BIT_EMPTY   = 2;
    localparam int BIT_FULL    = 3;
    localparam int BIT_OVF_REP = 4;
    localparam int BIT_OVF_CMD = 5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STB, S_WAIT} state_t;

endpackage

// File: rtl/jtbubl_comm_fifo.sv
// jtbubl_comm_fifo: byte FIFO of depth 2**AW with push, pop, flush and occupancy count
module jtbubl_comm_fifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(2**AW);
    assign empty   = count == '0;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/jtbubl_main_comm.sv
// jtbubl_main_comm: main-CPU end of the main/sound mailbox; reply IRQ built only with JTBUBL_COMM_IRQ_EN
module jtbubl_main_comm
    import jtbubl_comm_pkg::*;
#(
    parameter int CMD_AW   = 2,
    parameter int WAIT_MAX = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_cs,
    input  logic [1:0] addr,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic [7:0] snd_latch,
    output logic       snd_stb,
    input  logic       snd_flag,
    input  logic [7:0] main_latch,
    input  logic       main_stb,
    output logic       main_flag,
    output logic       snd_rstn,
    output logic       irq_n
);
    localparam int WW = WAIT_MAX > 0 ? $clog2(WAIT_MAX + 1) : 1;

    state_t        state, next_state;
    logic [WW-1:0] wait_cnt;
    logic          wr_act, rd_act, wr_l, rd_l, stb_l;
    logic          wr_first, rd_first, rep_rise;
    logic          push, pop, flush, ctrl_wr, data_rd, stat_rd;
    logic          full, empty, busy, ovf_cmd, ovf_rep;
    logic [CMD_AW:0] fifo_count;
    logic [7:0]    head, reply, status, rd_data;

    assign wr_act   = cpu_cs & ~wr_n;
    assign rd_act   = cpu_cs & ~rd_n;
    assign wr_first = wr_act & ~wr_l;
    assign rd_first = rd_act & ~rd_l;
    assign rep_rise = main_stb & ~stb_l;
    assign push     = wr_first && addr == REG_DATA;
    assign flush    = wr_first && addr == REG_FLUSH;
    assign ctrl_wr  = wr_first && addr == REG_CTRL;
    assign data_rd  = rd_first && addr == REG_DATA;
    assign stat_rd  = rd_first && addr == REG_CTRL;
    assign pop      = state == S_LOAD;
    assign busy     = state != S_IDLE || !snd_flag;
    assign status   = {2'b0, ovf_cmd, ovf_rep, full, empty, main_flag, busy};

    jtbubl_comm_fifo #(.AW(CMD_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (cpu_dout),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        next_state = state;
        snd_stb    = state == S_STB;
        case (state)
            S_IDLE: if (!empty && snd_flag && snd_rstn) next_state = S_LOAD;
            S_LOAD: next_state = S_STB;
            S_STB:  next_state = S_WAIT;
            S_WAIT: if (!snd_flag || wait_cnt == WW'(WAIT_MAX)) next_state = S_IDLE;
        endcase
        if (flush || !snd_rstn) next_state = S_IDLE;
    end

    always_comb
        rd_data = addr == REG_DATA  ? reply  :
                  addr == REG_CTRL  ? status :
                  addr == REG_COUNT ? 8'(fifo_count) : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            wr_l      <= 1'b0;
            rd_l      <= 1'b0;
            stb_l     <= 1'b0;
            snd_latch <= 8'h00;
            reply     <= 8'h00;
            main_flag <= 1'b0;
            ovf_cmd   <= 1'b0;
            ovf_rep   <= 1'b0;
            snd_rstn  <= 1'b0;
            cpu_din   <= 8'hFF;
        end else begin
            state     <= next_state;
            wait_cnt  <= state == S_WAIT ? wait_cnt + 1'b1 : '0;
            wr_l      <= wr_act;
            rd_l      <= rd_act;
            stb_l     <= main_stb;
            if (state == S_LOAD) snd_latch <= head;
            if (ctrl_wr) snd_rstn <= ~cpu_dout[0];
            if (rd_act) cpu_din <= rd_data;
            if (rep_rise) reply <= main_latch;
            // a capture on the same edge as the data read wins over the clear
            main_flag <= rep_rise | (main_flag & ~data_rd);
            ovf_rep   <= (rep_rise & main_flag) | (ovf_rep & ~stat_rd);
            ovf_cmd   <= (push & full & ~pop) | (ovf_cmd & ~stat_rd);
        end
    end

`ifdef JTBUBL_COMM_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq_n  <= 1'b1;
        end else begin
            if (ctrl_wr) irq_en <= cpu_dout[1];
            irq_n <= ~(main_flag & irq_en);
        end
    end
`else
    assign irq_n = 1'b1;
`endif
endmodule

// File: tb/tb_jtbubl_main_comm.sv
// tb_jtbubl_main_comm: directed self-checking bench for the main/sound mailbox
module tb_jtbubl_main_comm;
    localparam int WAIT_MAX = 1023;
`ifdef JTBUBL_COMM_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_cs = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] cpu_dout = 8'h00;
    logic [7:0] cpu_din;
    logic [7:0] snd_latch;
    logic       snd_stb;
    logic       snd_flag = 1'b1;
    logic [7:0] main_latch = 8'h00;
    logic       main_stb = 1'b0;
    logic       main_flag;
    logic       snd_rstn;
    logic       irq_n;

    int checks = 0;
    int errs = 0;

    always #5 clk = ~clk;

    jtbubl_main_comm #(.CMD_AW(2), .WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_cs     (cpu_cs),
        .addr       (addr),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .snd_latch  (snd_latch),
        .snd_stb    (snd_stb),
        .snd_flag   (snd_flag),
        .main_latch (main_latch),
        .main_stb   (main_stb),
        .main_flag  (main_flag),
        .snd_rstn   (snd_rstn),
        .irq_n      (irq_n)
    );

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_cs = 1'b1; wr_n = 1'b0; addr = a; cpu_dout = d;
        @(negedge clk);
        cpu_cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_cs = 1'b1; rd_n = 1'b0; addr = a;
        @(negedge clk);
        cpu_cs = 1'b0; rd_n = 1'b1;
        d = cpu_din;
    endtask

    task automatic wait_stb(input int bound, output int n);
        n = 0;
        while (!snd_stb && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        main_latch = b; main_stb = 1'b1;
        @(negedge clk);
        main_stb = 1'b0;
    endtask

    // sound model: takes one strobed byte, drops snd_flag a clk later, re-raises it after hold clks
    task automatic deliver(input logic [7:0] exp, input int hold);
        int  n;
        logic bad;
        wait_stb(50, n);
        checks++;
        if (snd_stb !== 1'b1) begin
            errs++; $display("FAIL deliver_timeout: snd_stb %b expected 1 for byte %h", snd_stb, exp);
        end else if (snd_latch !== exp) begin
            errs++; $display("FAIL deliver_byte: snd_latch %h expected %h", snd_latch, exp);
        end
        @(negedge clk);
        checks++;
        if (snd_stb !== 1'b0) begin
            errs++; $display("FAIL stb_width: snd_stb %b expected 0", snd_stb);
        end
        snd_flag = 1'b0;
        bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (snd_stb) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errs++; $display("FAIL stb_while_busy: strobe seen %b expected 0", bad);
        end
        snd_flag = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({snd_latch, snd_stb, main_flag, snd_rstn, irq_n, cpu_din} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF}) begin
            errs++;
            $display("FAIL reset_outputs: latch=%h stb=%b mflag=%b rstn=%b irq_n=%b din=%h expected 00 0 0 0 1 FF",
                     snd_latch, snd_stb, main_flag, snd_rstn, irq_n, cpu_din);
        end
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h04) begin errs++; $display("FAIL reset_status: got %h expected 04", d); end
        cpu_rd(2'd3, d);
        checks++;
        if (d !== 8'hFF) begin errs++; $display("FAIL addr3_read: got %h expected FF", d); end
    endtask

    task automatic test_single();
        logic [7:0] d;
        cpu_wr(2'd1, 8'h00);
        checks++;
        if (snd_rstn !== 1'b1) begin errs++; $display("FAIL release_rstn: got %b expected 1", snd_rstn); end
        cpu_wr(2'd0, 8'h5A);
        checks++;
        if (snd_stb !== 1'b0) begin errs++; $display("FAIL lat_c1: snd_stb %b expected 0", snd_stb); end
        @(negedge clk);
        checks++;
        if (snd_stb !== 1'b0) begin errs++; $display("FAIL lat_c2: snd_stb %b expected 0", snd_stb); end
        @(negedge clk);
        checks++;
        if ({snd_stb, snd_latch} !== {1'b1, 8'h5A}) begin
            errs++; $display("FAIL lat_c3: stb=%b latch=%h expected 1 5A", snd_stb, snd_latch);
        end
        @(negedge clk);
        checks++;
        if (snd_stb !== 1'b0) begin errs++; $display("FAIL lat_c4: snd_stb %b expected 0", snd_stb); end
        snd_flag = 1'b0;
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h05) begin errs++; $display("FAIL busy_status: got %h expected 05", d); end
        snd_flag = 1'b1;
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h04) begin errs++; $display("FAIL idle_status: got %h expected 04", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        snd_flag = 1'b0;
        for (int i = 1; i <= 5; i++) cpu_wr(2'd0, 8'(i));
        cpu_rd(2'd2, d);
        checks++;
        if (d !== 8'h04) begin errs++; $display("FAIL full_count: got %h expected 04", d); end
        snd_flag = 1'b1;
        deliver(8'h01, 3);
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h21) begin errs++; $display("FAIL ovf_status: got %h expected 21", d); end
        for (int i = 2; i <= 4; i++) deliver(8'(i), 4);
        cpu_rd(2'd2, d);
        checks++;
        if (d !== 8'h00) begin errs++; $display("FAIL drained_count: got %h expected 00", d); end
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h04) begin errs++; $display("FAIL ovf_cleared: got %h expected 04", d); end
    endtask

    task automatic test_reply();
        logic [7:0] d;
        cpu_wr(2'd1, 8'h02);
        pulse(8'hC3);
        checks++;
        if (main_flag !== 1'b1) begin errs++; $display("FAIL reply_flag: got %b expected 1", main_flag); end
        @(negedge clk);
        checks++;
        if (irq_n !== !IRQ_ON) begin errs++; $display("FAIL irq_assert: got %b expected %b", irq_n, !IRQ_ON); end
        cpu_rd(2'd0, d);
        checks++;
        if ({d, main_flag} !== {8'hC3, 1'b0}) begin
            errs++; $display("FAIL reply_read: data=%h flag=%b expected C3 0", d, main_flag);
        end
        @(negedge clk);
        checks++;
        if (irq_n !== 1'b1) begin errs++; $display("FAIL irq_release: got %b expected 1", irq_n); end
        pulse(8'h11);
        pulse(8'h22);
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h16) begin errs++; $display("FAIL ovf_rep_status: got %h expected 16", d); end
        cpu_rd(2'd0, d);
        checks++;
        if (d !== 8'h22) begin errs++; $display("FAIL latest_reply: got %h expected 22", d); end
    endtask

    task automatic test_read_hold();
        logic [7:0] d;
        pulse(8'h44);
        @(negedge clk);
        cpu_cs = 1'b1; rd_n = 1'b0; addr = 2'd0;
        @(negedge clk);
        checks++;
        if (main_flag !== 1'b0) begin errs++; $display("FAIL hold_clear: got %b expected 0", main_flag); end
        @(negedge clk);
        main_latch = 8'h55; main_stb = 1'b1;
        @(negedge clk);
        main_stb = 1'b0;
        repeat (3) @(negedge clk);
        cpu_cs = 1'b0; rd_n = 1'b1;
        checks++;
        if ({main_flag, cpu_din} !== {1'b1, 8'h55}) begin
            errs++; $display("FAIL hold_recapture: flag=%b din=%h expected 1 55", main_flag, cpu_din);
        end
        @(negedge clk);
        cpu_cs = 1'b1; rd_n = 1'b0; addr = 2'd0; main_latch = 8'h66; main_stb = 1'b1;
        @(negedge clk);
        cpu_cs = 1'b0; rd_n = 1'b1; main_stb = 1'b0;
        checks++;
        if ({main_flag, cpu_din} !== {1'b1, 8'h55}) begin
            errs++; $display("FAIL coincide: flag=%b din=%h expected 1 55", main_flag, cpu_din);
        end
        cpu_rd(2'd0, d);
        checks++;
        if ({d, main_flag} !== {8'h66, 1'b0}) begin
            errs++; $display("FAIL coincide_read: data=%h flag=%b expected 66 0", d, main_flag);
        end
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h14) begin errs++; $display("FAIL coincide_status: got %h expected 14", d); end
    endtask

    task automatic test_timeout();
        int n;
        cpu_wr(2'd1, 8'h01);
        cpu_wr(2'd0, 8'hA1);
        cpu_wr(2'd0, 8'hA2);
        cpu_wr(2'd0, 8'hA3);
        cpu_wr(2'd1, 8'h00);
        wait_stb(20, n);
        checks++;
        if ({snd_stb, snd_latch} !== {1'b1, 8'hA1}) begin
            errs++; $display("FAIL timeout_first: stb=%b latch=%h expected 1 A1", snd_stb, snd_latch);
        end
        @(negedge clk);
        wait_stb(1100, n);
        checks++;
        if ({snd_stb, snd_latch} !== {1'b1, 8'hA2}) begin
            errs++; $display("FAIL timeout_next: stb=%b latch=%h expected 1 A2", snd_stb, snd_latch);
        end
        checks++;
        if (n + 1 !== WAIT_MAX + 4) begin
            errs++; $display("FAIL timeout_gap: got %0d cycles expected %0d", n + 1, WAIT_MAX + 4);
        end
    endtask

    task automatic test_snd_reset();
        logic [7:0] d;
        logic bad;
        repeat (3) @(negedge clk);
        cpu_wr(2'd1, 8'h01);
        checks++;
        if (snd_rstn !== 1'b0) begin errs++; $display("FAIL hold_rstn: got %b expected 0", snd_rstn); end
        cpu_rd(2'd1, d);
        checks++;
        if (d !== 8'h00) begin errs++; $display("FAIL reset_idle_status: got %h expected 00", d); end
        cpu_rd(2'd2, d);
        checks++;
        if (d !== 8'h01) begin errs++; $display("FAIL reset_keep_count: got %h expected 01", d); end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (snd_stb) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errs++; $display("FAIL stb_in_reset: strobe seen %b expected 0", bad); end
        cpu_wr(2'd2, 8'h00);
        cpu_rd(2'd2, d);
        checks++;
        if (d !== 8'h00) begin errs++; $display("FAIL flush_count: got %h expected 00", d); end
        cpu_wr(2'd1, 8'h00);
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (snd_stb) bad = 1'b1;
        end
        checks++;
        if ({bad, snd_rstn} !== 2'b01) begin
            errs++; $display("FAIL after_flush: strobe=%b rstn=%b expected 0 1", bad, snd_rstn);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_reply();
        test_read_hold();
        test_timeout();
        test_snd_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
